ram_responder: RTL
==================

// Module: ram_responder
// PURPOSE
//  Memory-side end of the ramREN/ramWEN/ramstate protocol used by icache/dcache/arbiter.
//  Accepts one word request at a time, models LAT-cycle access latency and reports
//  progress as ramstate_t (FREE/BUSY/ACCESS/ERROR) from cpu_types_pkg.
//  Word-addressed backing store of DEPTH words. Used as the main memory for
//  simulation and FPGA builds.
// PARAMETERS
//  LAT    2     BUSY cycles before ACCESS (0 allowed: ACCESS directly after sample)
//  DEPTH  1024  words of storage; power of 2; index = ramaddr[2+log2(DEPTH)-1:2]
// PORTS
//  CLK       in   1       clock, rising edge
//  RST       in   1       reset, synchronous, active-high
//  ramREN    in   1       read request, held until ACCESS seen
//  ramWEN    in   1       write request, held until ACCESS seen
//  ramaddr   in   WORD_W  byte address, must be word aligned
//  ramstore  in   WORD_W  write data
//  ramload   out  WORD_W  read data, valid only while ramstate==ACCESS
//  ramstate  out  2       ramstate_t; registered
// BEHAVIOUR
//  - FSM states: IDLE (out FREE), WAIT (out BUSY), DONE (out ACCESS), ERR (out ERROR).
//  - Reset: state IDLE, ramstate=FREE, ramload=0, latency counter=0. Memory not cleared.
//  - Request = ramREN^ramWEN. Bad request = (ramREN&ramWEN) | ramaddr[1:0]!=0
//    | out-of-range (see CONFIGURATION). Bad request sampled in IDLE/DONE/WAIT -> ERR.
//  - IDLE/DONE at edge: no request -> IDLE; valid request -> latch addr/REN/WEN/store,
//    load counter=LAT; go WAIT if LAT>0 else DONE.
//  - WAIT: decrement counter each edge; outputs BUSY. When counter reaches 1 -> DONE.
//    Request sampled at edge t: BUSY cycles t+1..t+LAT, ACCESS at cycle t+LAT+1.
//  - Request change in WAIT (addr, REN, WEN or store differ from latch): restart --
//    relatch, reload counter=LAT, stay WAIT (LAT>0). Request dropped in WAIT -> IDLE,
//    nothing committed.
//  - Entering DONE: read -> ramload<=mem[idx]; write -> mem[idx]<=latched store,
//    ramload<=0. DONE lasts exactly one cycle; next-state evaluated as IDLE, so
//    back-to-back requests from the cache get no extra FREE cycle.
//  - ERR: outputs ERROR, ramload=0, held while bad request persists; valid request ->
//    handled as from IDLE; no request -> IDLE. Nothing ever written from ERR.
//  - Write then read same address: read returns the new data (write committed on
//    DONE entry, before any following request is sampled).
//  - ramload=0 in every state except DONE.
//  - RST mid-operation: any pending write is dropped, outputs return to reset values.
// CONFIGURATION
//  RAM_OOR_ERROR_EN defined: ramaddr[WORD_W-1:2] >= DEPTH is a bad request -> ERROR.
//  Not defined: upper address bits ignored, index wraps modulo DEPTH (aliasing).
// TESTING
//  1 Reset held 2 cycles -> ramstate=FREE, ramload=0; idle 5 cycles stays FREE.
//  2 LAT=2: write 0xDEADBEEF @0x40 -> BUSY,BUSY,ACCESS; then read @0x40 ->
//    BUSY,BUSY,ACCESS with ramload=0xDEADBEEF, ramload=0 next cycle.
//  3 ramREN=ramWEN=1 @0x40, and separately read @0x1002 -> ERROR while held,
//    FREE after drop; mem[0x40] still 0xDEADBEEF.
//  4 Read @0x40 then after 1 BUSY change addr to 0x44 (holding 0x12345678) ->
//    counter restarts, ACCESS LAT+1 cycles after change, ramload=0x12345678.
//  5 DEPTH=1024, read @0x1000 -> with RAM_OOR_ERROR_EN: ERROR; without: ACCESS
//    with ramload=mem[0].
//  6 Write 0xCAFEF00D @0x80, assert RST during BUSY -> FREE next cycle; read @0x80
//    returns previous contents, not 0xCAFEF00D.

Source files
------------

// File: rtl/ram_responder.sv
// ram_responder: memory side of the ramREN/ramWEN/ramstate handshake.
// Optional RAM_OOR_ERROR_EN: out-of-range word address reports ERROR instead of aliasing.
module ram_responder #(
   parameter int WORD_W = 32,
   parameter int LAT    = 2,
   parameter int DEPTH  = 1024
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ramREN,
   input  logic              ramWEN,
   input  logic [WORD_W-1:0] ramaddr,
   input  logic [WORD_W-1:0] ramstore,
   output logic [WORD_W-1:0] ramload,
   output logic [1:0]        ramstate
);

   // state codes double as the ramstate_t encoding (FREE/BUSY/ACCESS/ERROR)
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);

   logic [1:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WORD_W-1:0] addr_q, addr_d;
   logic [WORD_W-1:0] store_q, store_d;
   logic              ren_q, ren_d;
   logic              wen_q, wen_d;
   logic [WORD_W-1:0] ramload_q;

   logic              req, bad, oor, changed;
   logic              rd_go, wr_go;
   logic [AW-1:0]     acc_idx;
   logic [WORD_W-1:0] acc_data;

   logic [WORD_W-1:0] mem [DEPTH];

`ifdef RAM_OOR_ERROR_EN
   assign oor = |ramaddr[WORD_W-1:AW+2];
`else
   assign oor = 1'b0;
`endif

   assign req     = ramREN ^ ramWEN;
   assign bad     = (ramREN & ramWEN) | (ramaddr[1:0] != 2'b00) | oor;
   assign changed = (ramaddr != addr_q) | (ramREN != ren_q)
                  | (ramWEN != wen_q) | (ramstore != store_q);

   // next state, request latch and access strobes
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      store_d  = store_q;
      ren_d    = ren_q;
      wen_d    = wen_q;
      rd_go    = 1'b0;
      wr_go    = 1'b0;
      acc_idx  = addr_q[AW+1:2];
      acc_data = store_q;
      unique case (state_q)
         S_WAIT: begin
            if (bad) begin
               state_d = S_ERR;
            end else if (!req) begin
               state_d = S_IDLE;
            end else if (changed) begin
               addr_d  = ramaddr;
               store_d = ramstore;
               ren_d   = ramREN;
               wen_d   = ramWEN;
               cnt_d   = CW'(LAT);
            end else if (cnt_q == CW'(1)) begin
               state_d = S_DONE;
               rd_go   = ren_q;
               wr_go   = wen_q;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            // IDLE, DONE and ERR all sample a fresh request
            if (bad) begin
               state_d = S_ERR;
            end else if (!req) begin
               state_d = S_IDLE;
            end else begin
               addr_d  = ramaddr;
               store_d = ramstore;
               ren_d   = ramREN;
               wen_d   = ramWEN;
               cnt_d   = CW'(LAT);
               if (LAT > 0) begin
                  state_d = S_WAIT;
               end else begin
                  state_d  = S_DONE;
                  rd_go    = ramREN;
                  wr_go    = ramWEN;
                  acc_idx  = ramaddr[AW+1:2];
                  acc_data = ramstore;
               end
            end
         end
      endcase
   end

   // control registers and read data; read data is zero outside DONE
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         store_q   <= '0;
         ren_q     <= 1'b0;
         wen_q     <= 1'b0;
         ramload_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         store_q   <= store_d;
         ren_q     <= ren_d;
         wen_q     <= wen_d;
         ramload_q <= rd_go ? mem[acc_idx] : '0;
      end
   end

   // backing store; a reset on the commit edge drops the write
   always_ff @(posedge CLK) begin
      if (!RST && wr_go) begin
         mem[acc_idx] <= acc_data;
      end
   end

   assign ramload  = ramload_q;
   assign ramstate = state_q;

endmodule
